// File: rtl/acc_pkg.sv
// Shared definitions for the Exe-stage accumulator file and its writers:
// data/index widths, write-vector layout, clear value and clear FSM states.
package acc_pkg;

  localparam int unsigned DW     = 32;
  localparam int unsigned NACC   = 16;
  localparam int unsigned IW     = 4;
  localparam int unsigned VW     = 5;
  localparam int unsigned CNT_W  = 16;

  // Write-vector field positions: [WEN_BIT] = enable, [IDX_MSB:IDX_LSB] = index
  localparam int unsigned WEN_BIT = 4;
  localparam int unsigned IDX_MSB = 3;
  localparam int unsigned IDX_LSB = 0;

  localparam logic [DW-1:0] CLR_VAL = 32'h0000_0000;

  // Packed view of a write vector, bit-compatible with the field positions above
  typedef struct packed {
    logic          en;
    logic [IW-1:0] idx;
  } wen_vctr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CLR  = 1'b1
  } clr_state_e;

endpackage

// File: rtl/acc_file_if.sv
// Write/read bus between the Int0/Int1 units, the Exe decoder and acc_file.
//   master : Int units / decoder side (drives write vectors, stall, clear request)
//   slave  : acc_file (drives accumulator values, clear busy, write counter)
interface acc_file_if;
  import acc_pkg::*;

  logic [VW-1:0]    wen_vctr0_i_accf;
  logic [DW-1:0]    wdata0_i_accf;
  logic [VW-1:0]    wen_vctr1_i_accf;
  logic [DW-1:0]    wdata1_i_accf;
  logic             stall_i_accf;
  logic             clr_req_i_accf;

  logic [DW-1:0]    acc00_o_accf, acc01_o_accf, acc02_o_accf, acc03_o_accf;
  logic [DW-1:0]    acc04_o_accf, acc05_o_accf, acc06_o_accf, acc07_o_accf;
  logic [DW-1:0]    acc08_o_accf, acc09_o_accf, acc10_o_accf, acc11_o_accf;
  logic [DW-1:0]    acc12_o_accf, acc13_o_accf, acc14_o_accf, acc15_o_accf;
  logic             clr_busy_o_accf;
  logic [CNT_W-1:0] wr_cnt_o_accf;

  modport master (
    output wen_vctr0_i_accf, wdata0_i_accf, wen_vctr1_i_accf, wdata1_i_accf,
    output stall_i_accf, clr_req_i_accf,
    input  acc00_o_accf, acc01_o_accf, acc02_o_accf, acc03_o_accf,
    input  acc04_o_accf, acc05_o_accf, acc06_o_accf, acc07_o_accf,
    input  acc08_o_accf, acc09_o_accf, acc10_o_accf, acc11_o_accf,
    input  acc12_o_accf, acc13_o_accf, acc14_o_accf, acc15_o_accf,
    input  clr_busy_o_accf, wr_cnt_o_accf
  );

  modport slave (
    input  wen_vctr0_i_accf, wdata0_i_accf, wen_vctr1_i_accf, wdata1_i_accf,
    input  stall_i_accf, clr_req_i_accf,
    output acc00_o_accf, acc01_o_accf, acc02_o_accf, acc03_o_accf,
    output acc04_o_accf, acc05_o_accf, acc06_o_accf, acc07_o_accf,
    output acc08_o_accf, acc09_o_accf, acc10_o_accf, acc11_o_accf,
    output acc12_o_accf, acc13_o_accf, acc14_o_accf, acc15_o_accf,
    output clr_busy_o_accf, wr_cnt_o_accf
  );

endinterface

// File: rtl/acc_clr_seq.sv
// Bulk-clear sequencer: walks clr_idx 0..NACC-1, one accumulator per cycle.
//   clk, rst    : clock, synchronous active-high reset
//   clr_req     : clear request (ignored while a clear runs)
//   clr_busy    : registered, high for the whole clear
//   clr_we_c    : clear-write strobe for the current clr_idx
//   clr_idx     : registered index being cleared
//   wr_ok_c     : lane commits allowed (idle and no request this edge)
module acc_clr_seq
  import acc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_we_c,
  output logic [IW-1:0] clr_idx,
  output logic          wr_ok_c
);

  clr_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;

  // Next-state: start on request from idle, finish after the last index
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLR;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_CLR: begin
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NACC - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  assign clr_busy = busy_q;
  assign clr_idx  = idx_q;
  assign clr_we_c = (state_q == ST_CLR);
  // Writes on the request edge are dropped along with those during the clear
  assign wr_ok_c  = (state_q == ST_IDLE) && !clr_req;

endmodule

// File: rtl/acc_file.sv
// Exe-stage accumulator file: 16 x DW registers with two write lanes
// (lane1 wins on same-index collision), a committed-write counter and a
// sequenced bulk clear.
//   clk, rst : clock, synchronous active-high reset
//   bus      : acc_file_if.slave (write vectors/data, stall, clear request in;
//              acc00..acc15, clr_busy, wr_cnt out; all outputs registered)
module acc_file
  import acc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  acc_file_if.slave bus
);

  logic [DW-1:0]    acc_q [NACC];
  logic [DW-1:0]    acc_d [NACC];
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  wen_vctr_t        wv0_c, wv1_c;
  logic             commit0_c, commit1_c;
  logic             clr_we_c, wr_ok_c, clr_busy;
  logic [IW-1:0]    clr_idx;

  acc_clr_seq u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req_i_accf),
    .clr_busy (clr_busy),
    .clr_we_c (clr_we_c),
    .clr_idx  (clr_idx),
    .wr_ok_c  (wr_ok_c)
  );

  // Lane commit qualification
  always_comb begin
    wv0_c     = wen_vctr_t'(bus.wen_vctr0_i_accf);
    wv1_c     = wen_vctr_t'(bus.wen_vctr1_i_accf);
    commit0_c = wv0_c.en && !bus.stall_i_accf && wr_ok_c;
    commit1_c = wv1_c.en && !bus.stall_i_accf && wr_ok_c;
  end

  // Array next-state: lane1 applied after lane0 so it wins a collision;
  // clear writes never coincide with lane commits
  always_comb begin
    acc_d = acc_q;
    if (commit0_c) acc_d[wv0_c.idx] = bus.wdata0_i_accf;
    if (commit1_c) acc_d[wv1_c.idx] = bus.wdata1_i_accf;
    if (clr_we_c)  acc_d[clr_idx]   = CLR_VAL;
  end

  // Collisions count both lanes
  always_comb begin
    wr_cnt_d = wr_cnt_q + CNT_W'(commit0_c) + CNT_W'(commit1_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NACC; i++) acc_q[i] <= CLR_VAL;
      wr_cnt_q <= '0;
    end else begin
      acc_q    <= acc_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign bus.acc00_o_accf    = acc_q[0];
  assign bus.acc01_o_accf    = acc_q[1];
  assign bus.acc02_o_accf    = acc_q[2];
  assign bus.acc03_o_accf    = acc_q[3];
  assign bus.acc04_o_accf    = acc_q[4];
  assign bus.acc05_o_accf    = acc_q[5];
  assign bus.acc06_o_accf    = acc_q[6];
  assign bus.acc07_o_accf    = acc_q[7];
  assign bus.acc08_o_accf    = acc_q[8];
  assign bus.acc09_o_accf    = acc_q[9];
  assign bus.acc10_o_accf    = acc_q[10];
  assign bus.acc11_o_accf    = acc_q[11];
  assign bus.acc12_o_accf    = acc_q[12];
  assign bus.acc13_o_accf    = acc_q[13];
  assign bus.acc14_o_accf    = acc_q[14];
  assign bus.acc15_o_accf    = acc_q[15];
  assign bus.clr_busy_o_accf = clr_busy;
  assign bus.wr_cnt_o_accf   = wr_cnt_q;

endmodule

// File: tb/tb_acc_file.sv
// Scoreboard bench for acc_file: each driven cycle pushes the expected
// post-edge state; a monitor pops and compares it just after the edge.
module tb_acc_file;
  import acc_pkg::*;

  typedef struct packed {
    logic [15:0][31:0] acc;
    logic              busy;
    logic [15:0]       cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acc_file_if bus ();

  acc_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] dut_acc [16];
  assign dut_acc[0]  = bus.acc00_o_accf;
  assign dut_acc[1]  = bus.acc01_o_accf;
  assign dut_acc[2]  = bus.acc02_o_accf;
  assign dut_acc[3]  = bus.acc03_o_accf;
  assign dut_acc[4]  = bus.acc04_o_accf;
  assign dut_acc[5]  = bus.acc05_o_accf;
  assign dut_acc[6]  = bus.acc06_o_accf;
  assign dut_acc[7]  = bus.acc07_o_accf;
  assign dut_acc[8]  = bus.acc08_o_accf;
  assign dut_acc[9]  = bus.acc09_o_accf;
  assign dut_acc[10] = bus.acc10_o_accf;
  assign dut_acc[11] = bus.acc11_o_accf;
  assign dut_acc[12] = bus.acc12_o_accf;
  assign dut_acc[13] = bus.acc13_o_accf;
  assign dut_acc[14] = bus.acc14_o_accf;
  assign dut_acc[15] = bus.acc15_o_accf;

  int n_vec = 0;
  int n_err = 0;

  exp_t  exp_q [$];
  string tag_q [$];

  // Reference state
  logic [15:0][31:0] m_acc;
  logic              m_busy;
  int                m_pos;
  logic [15:0]       m_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle at the falling edge and push the expected post-edge state
  task automatic step(input bit r, input bit e0, input logic [3:0] i0, input logic [31:0] d0,
                      input bit e1, input logic [3:0] i1, input logic [31:0] d1,
                      input bit st, input bit cr, input string tag);
    exp_t e;
    @(negedge clk);
    rst                  = r;
    bus.wen_vctr0_i_accf = {e0, i0};
    bus.wdata0_i_accf    = d0;
    bus.wen_vctr1_i_accf = {e1, i1};
    bus.wdata1_i_accf    = d1;
    bus.stall_i_accf     = st;
    bus.clr_req_i_accf   = cr;
    if (r) begin
      m_acc  = '0;
      m_busy = 1'b0;
      m_cnt  = '0;
    end else if (m_busy) begin
      m_acc[m_pos] = 32'h0;
      m_pos++;
      if (m_pos == 16) m_busy = 1'b0;
    end else if (cr) begin
      m_busy = 1'b1;
      m_pos  = 0;
    end else if (!st) begin
      if (e0) begin m_acc[i0] = d0; m_cnt++; end
      if (e1) begin m_acc[i1] = d1; m_cnt++; end
    end
    e.acc  = m_acc;
    e.busy = m_busy;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0, tag);
  endtask

  // Monitor: compare just after each rising edge
  always @(posedge clk) begin
    exp_t  e;
    string t;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      for (int i = 0; i < 16; i++)
        check_val($sformatf("%s.acc%0d", t, i), dut_acc[i], e.acc[i]);
      check_val({t, ".busy"}, 32'(bus.clr_busy_o_accf), 32'(e.busy));
      check_val({t, ".cnt"}, 32'(bus.wr_cnt_o_accf), 32'(e.cnt));
    end
  end

  initial begin
    bus.wen_vctr0_i_accf = '0;
    bus.wdata0_i_accf    = '0;
    bus.wen_vctr1_i_accf = '0;
    bus.wdata1_i_accf    = '0;
    bus.stall_i_accf     = 1'b0;
    bus.clr_req_i_accf   = 1'b0;
    m_acc  = '0;
    m_busy = 1'b0;
    m_pos  = 0;
    m_cnt  = '0;

    step(1, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0, "rst0");
    // Preload then reset
    step(0, 1, 4'd1, 32'h0123_4567, 1, 4'd4, 32'h89AB_CDEF, 0, 0, "preload");
    step(1, 1, 4'd6, 32'h5555_5555, 0, 4'd0, 32'h0, 0, 0, "rst1");
    idle("post_rst");
    // Single lane1 write
    step(0, 0, 4'd0, 32'h0, 1, 4'd3, 32'hDEAD_BEEF, 0, 0, "single");
    // Dual distinct, then colliding
    step(0, 1, 4'd2, 32'h1111, 1, 4'd5, 32'h2222, 0, 0, "dual");
    step(0, 1, 4'd7, 32'hAAAA, 1, 4'd7, 32'hBBBB, 0, 0, "collide");
    // Stalled then released
    step(0, 1, 4'd9, 32'h9999_0000, 0, 4'd0, 32'h0, 1, 0, "stall");
    step(0, 1, 4'd9, 32'h9999_0000, 0, 4'd0, 32'h0, 0, 0, "unstall");
    // Fill all, then bulk clear with a write on the request edge
    for (int i = 0; i < 8; i++)
      step(0, 1, 4'(2*i), $urandom, 1, 4'(2*i+1), $urandom, 0, 0, "fill");
    step(0, 1, 4'd4, 32'hFEED_0004, 1, 4'd8, 32'hFEED_0008, 0, 1, "clr_req");
    for (int i = 0; i < 16; i++) begin
      if (i == 2)
        step(0, 0, 4'd0, 32'h0, 1, 4'd0, 32'hBAD0_0000, 0, 0, "clr_wr_drop");
      else if (i == 8)
        step(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 1, "clr_req_again");
      else
        idle("clr");
    end
    idle("clr_done");
    step(0, 1, 4'd15, 32'h0F0F_0F0F, 0, 4'd0, 32'h0, 0, 0, "post_clr_wr");
    // Reset mid-clear at clr_idx = 6
    for (int i = 0; i < 8; i++)
      step(0, 1, 4'(2*i), $urandom, 1, 4'(2*i+1), $urandom, 0, 0, "fill2");
    step(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 1, "clr_req2");
    for (int i = 0; i < 6; i++) idle("clr2");
    step(1, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0, "rst_mid_clr");
    step(0, 0, 4'd0, 32'h0, 1, 4'd11, 32'hC0DE_0011, 0, 0, "wr_after_rst");
    // Random mix including occasional clears
    for (int i = 0; i < 60; i++)
      step(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), "rand");
    idle("tail");

    for (int k = 0; k < 8 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    check_val("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
